// File: rtl/imem_dport_arbiter_pkg.sv
// Shared definitions for the instruction-memory data-port arbiter:
// response tag encoding and the implemented memory address width.
package imem_dport_arbiter_pkg;

  localparam int IMEM_AW = 10;
  localparam int REQ_AW  = 29;
  localparam int DW      = 32;

  typedef enum logic [2:0] {
    TAG_NONE    = 3'd0,
    TAG_CPU_OK  = 3'd1,
    TAG_CPU_ERR = 3'd2,
    TAG_DBG_OK  = 3'd3,
    TAG_DBG_ERR = 3'd4
  } resp_tag_e;

  // Tag for a grant, given which requester owns it and whether the
  // address fell outside the implemented memory.
  function automatic resp_tag_e grant_tag(input logic is_dbg, input logic oor);
    if (is_dbg) return oor ? TAG_DBG_ERR : TAG_DBG_OK;
    return oor ? TAG_CPU_ERR : TAG_CPU_OK;
  endfunction

endpackage

// File: rtl/imem_starve_counter.sv
// Saturating count of consecutive cycles the debug requester was denied;
// at_limit forces the next debug request to win arbitration.
module imem_starve_counter
  import imem_dport_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= 4'd0;
    end else if (clr) begin
      cnt_reg <= 4'd0;
    end else if (inc && (cnt_reg != LIMIT)) begin
      cnt_reg <= cnt_reg + 4'd1;
    end
  end

  assign at_limit = (cnt_reg == LIMIT);

endmodule

// File: rtl/imem_dport_arbiter.sv
// Two-requester arbiter (CPU load path, debug monitor) for the data-side
// read port of the instruction memory, with starvation guard and range check.
module imem_dport_arbiter
  import imem_dport_arbiter_pkg::*;
#(
  parameter int AW           = IMEM_AW,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [REQ_AW-1:0] cpu_addr,
  output logic              cpu_gnt,
  output logic              cpu_valid,
  output logic [DW-1:0]     cpu_data,
  output logic              cpu_err,
  input  logic              dbg_req,
  input  logic [REQ_AW-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_valid,
  output logic [DW-1:0]     dbg_data,
  output logic              dbg_err,
  output logic              mem_en,
  output logic [AW-1:0]     mem_addr,
  input  logic [DW-1:0]     mem_data
);

  logic      dbg_at_limit;
  logic      starve_inc;
  logic      starve_clr;
  logic      cpu_oor;
  logic      dbg_oor;
  resp_tag_e tag_reg;
  resp_tag_e tag_next;

  assign cpu_oor = |cpu_addr[REQ_AW-1:AW];
  assign dbg_oor = |dbg_addr[REQ_AW-1:AW];

  // Grants are masked by reset so nothing is issued while rst is high.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (!rst) begin
      if (dbg_req && dbg_at_limit) begin
        dbg_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (dbg_req) begin
        dbg_gnt = 1'b1;
      end
    end
  end

  assign starve_inc = dbg_req & ~dbg_gnt;
  assign starve_clr = dbg_gnt | ~dbg_req;

  imem_starve_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc      (starve_inc),
    .clr      (starve_clr),
    .at_limit (dbg_at_limit)
  );

  // Out-of-range grants never touch memory but still get a response.
  always_comb begin
    mem_en   = 1'b0;
    mem_addr = '0;
    if (cpu_gnt && !cpu_oor) begin
      mem_en   = 1'b1;
      mem_addr = cpu_addr[AW-1:0];
    end else if (dbg_gnt && !dbg_oor) begin
      mem_en   = 1'b1;
      mem_addr = dbg_addr[AW-1:0];
    end
  end

  always_comb begin
    tag_next = TAG_NONE;
    if (cpu_gnt) begin
      tag_next = grant_tag(1'b0, cpu_oor);
    end else if (dbg_gnt) begin
      tag_next = grant_tag(1'b1, dbg_oor);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_reg <= TAG_NONE;
    end else begin
      tag_reg <= tag_next;
    end
  end

  // Index 0 is the CPU path, index 1 the debug path.
  logic [1:0]    resp_ok;
  logic [1:0]    resp_err;
  logic [DW-1:0] hold_reg [2];
  logic [DW-1:0] data_out [2];

  assign resp_ok[0]  = (tag_reg == TAG_CPU_OK);
  assign resp_err[0] = (tag_reg == TAG_CPU_ERR);
  assign resp_ok[1]  = (tag_reg == TAG_DBG_OK);
  assign resp_err[1] = (tag_reg == TAG_DBG_ERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) hold_reg[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (resp_ok[i]) begin
          hold_reg[i] <= mem_data;
        end else if (resp_err[i]) begin
          hold_reg[i] <= '0;
        end
      end
    end
  end

  // During the response cycle the memory data is forwarded directly;
  // afterwards the captured copy holds until the next response.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_resp
      assign data_out[gi] = resp_ok[gi]  ? mem_data :
                            resp_err[gi] ? '0       : hold_reg[gi];
    end
  endgenerate

  assign cpu_valid = resp_ok[0] | resp_err[0];
  assign cpu_err   = resp_err[0];
  assign cpu_data  = data_out[0];
  assign dbg_valid = resp_ok[1] | resp_err[1];
  assign dbg_err   = resp_err[1];
  assign dbg_data  = data_out[1];

endmodule

// File: tb/tb_imem_dport_arbiter.sv
// Directed bench for imem_dport_arbiter with a 1-cycle synchronous memory model.
module tb_imem_dport_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic [28:0] cpu_addr;
  logic        cpu_gnt;
  logic        cpu_valid;
  logic [31:0] cpu_data;
  logic        cpu_err;
  logic        dbg_req;
  logic [28:0] dbg_addr;
  logic        dbg_gnt;
  logic        dbg_valid;
  logic [31:0] dbg_data;
  logic        dbg_err;
  logic        mem_en;
  logic [9:0]  mem_addr;
  logic [31:0] mem_data;

  int n_checks = 0;
  int n_fail   = 0;

  imem_dport_arbiter #(.AW(10), .STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_gnt   (cpu_gnt),
    .cpu_valid (cpu_valid),
    .cpu_data  (cpu_data),
    .cpu_err   (cpu_err),
    .dbg_req   (dbg_req),
    .dbg_addr  (dbg_addr),
    .dbg_gnt   (dbg_gnt),
    .dbg_valid (dbg_valid),
    .dbg_data  (dbg_data),
    .dbg_err   (dbg_err),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: word i holds 0xC0DE0000 | i, except word 5.
  logic [31:0] mem [0:1023];
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[5] = 32'hDEAD_BEEF;
    mem_data = 32'h0;
  end
  always @(posedge clk) if (mem_en) mem_data <= mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0; dbg_req = 1'b0; dbg_addr = '0;
    tick(); tick();
    // Requests during reset must not be granted.
    cpu_req = 1'b1; cpu_addr = 29'h005; dbg_req = 1'b1; dbg_addr = 29'h006;
    #2;
    check("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    check("rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_cpu_valid", 32'(cpu_valid), 32'd0);
    check("rst_cpu_data", cpu_data, 32'd0);
    check("rst_dbg_data", dbg_data, 32'd0);
    cpu_req = 1'b0; dbg_req = 1'b0;
    tick();
    rst = 1'b0;
    $display("reset released");

    // Single CPU read of word 5.
    tick();
    cpu_req = 1'b1; cpu_addr = 29'h005;
    #2;
    check("t1_cpu_gnt", 32'(cpu_gnt), 32'd1);
    check("t1_mem_en", 32'(mem_en), 32'd1);
    check("t1_mem_addr", 32'(mem_addr), 32'd5);
    tick();
    cpu_req = 1'b0;
    #2;
    check("t1_cpu_valid", 32'(cpu_valid), 32'd1);
    check("t1_cpu_data", cpu_data, 32'hDEAD_BEEF);
    check("t1_cpu_err", 32'(cpu_err), 32'd0);
    check("t1_dbg_valid", 32'(dbg_valid), 32'd0);
    tick(); #2;
    check("t1_valid_drop", 32'(cpu_valid), 32'd0);
    tick(); tick(); #2;
    check("t1_cpu_hold", cpu_data, 32'hDEAD_BEEF);
    $display("txn cpu read 0x005 done");

    // Debug out-of-range read.
    tick();
    dbg_req = 1'b1; dbg_addr = 29'h400;
    #2;
    check("t3_dbg_gnt", 32'(dbg_gnt), 32'd1);
    check("t3_mem_en", 32'(mem_en), 32'd0);
    tick();
    dbg_req = 1'b0;
    #2;
    check("t3_dbg_valid", 32'(dbg_valid), 32'd1);
    check("t3_dbg_err", 32'(dbg_err), 32'd1);
    check("t3_dbg_data", dbg_data, 32'd0);
    check("t3_cpu_valid", 32'(cpu_valid), 32'd0);
    $display("txn dbg read 0x400 (out of range) done");

    // Continuous contention: debug wins every 5th cycle.
    for (int k = 1; k <= 10; k++) begin
      tick();
      cpu_req = 1'b1; cpu_addr = 29'h020; dbg_req = 1'b1; dbg_addr = 29'h030;
      #2;
      check($sformatf("t2_dbg_gnt_%0d", k), 32'(dbg_gnt), (k % 5 == 0) ? 32'd1 : 32'd0);
      check($sformatf("t2_cpu_gnt_%0d", k), 32'(cpu_gnt), (k % 5 == 0) ? 32'd0 : 32'd1);
      if (k > 1) begin
        check($sformatf("t2_cpu_valid_%0d", k), 32'(cpu_valid), ((k - 1) % 5 == 0) ? 32'd0 : 32'd1);
        check($sformatf("t2_dbg_valid_%0d", k), 32'(dbg_valid), ((k - 1) % 5 == 0) ? 32'd1 : 32'd0);
      end
      if (k == 6) check("t2_dbg_data_6", dbg_data, 32'hC0DE_0030);
      if (k == 7) check("t2_cpu_data_7", cpu_data, 32'hC0DE_0020);
      $display("txn contention cycle %0d cpu_gnt=%0b dbg_gnt=%0b", k, cpu_gnt, dbg_gnt);
    end
    tick();
    cpu_req = 1'b0; dbg_req = 1'b0;
    #2;
    check("t2_final_dbg_valid", 32'(dbg_valid), 32'd1);
    check("t2_final_dbg_data", dbg_data, 32'hC0DE_0030);

    // Back-to-back CPU reads.
    tick();
    cpu_req = 1'b1; cpu_addr = 29'h010;
    #2;
    check("t4_gnt0", 32'(cpu_gnt), 32'd1);
    tick();
    cpu_addr = 29'h011;
    #2;
    check("t4_mem_addr1", 32'(mem_addr), 32'h011);
    check("t4_valid0", 32'(cpu_valid), 32'd1);
    check("t4_data0", cpu_data, 32'hC0DE_0010);
    tick();
    cpu_addr = 29'h012;
    #2;
    check("t4_valid1", 32'(cpu_valid), 32'd1);
    check("t4_data1", cpu_data, 32'hC0DE_0011);
    tick();
    cpu_req = 1'b0;
    #2;
    check("t4_valid2", 32'(cpu_valid), 32'd1);
    check("t4_data2", cpu_data, 32'hC0DE_0012);
    tick(); #2;
    check("t4_valid_end", 32'(cpu_valid), 32'd0);
    $display("txn cpu back-to-back 0x010..0x012 done");

    // Reset pulsed in the cycle after a CPU grant.
    tick();
    cpu_req = 1'b1; cpu_addr = 29'h007;
    #2;
    check("t5_gnt", 32'(cpu_gnt), 32'd1);
    tick();
    cpu_req = 1'b0; rst = 1'b1;
    #2;
    check("t5_cpu_valid", 32'(cpu_valid), 32'd0);
    check("t5_cpu_data", cpu_data, 32'd0);
    check("t5_dbg_data", dbg_data, 32'd0);
    check("t5_mem_en", 32'(mem_en), 32'd0);
    tick();
    rst = 1'b0; cpu_req = 1'b1; cpu_addr = 29'h001;
    #2;
    check("t5_post_gnt", 32'(cpu_gnt), 32'd1);
    check("t5_post_mem_addr", 32'(mem_addr), 32'd1);
    tick();
    cpu_req = 1'b0;
    #2;
    check("t5_post_valid", 32'(cpu_valid), 32'd1);
    check("t5_post_data", cpu_data, 32'hC0DE_0001);
    $display("txn reset mid-read then cpu read 0x001 done");

    // Debug requests 2 cycles, drops 1, then needs the full 5 cycles again.
    for (int k = 1; k <= 8; k++) begin
      tick();
      cpu_req = 1'b1; cpu_addr = 29'h020;
      dbg_req = (k != 3); dbg_addr = 29'h031;
      #2;
      check($sformatf("t6_dbg_gnt_%0d", k), 32'(dbg_gnt), (k == 8) ? 32'd1 : 32'd0);
      $display("txn starve-clear cycle %0d dbg_req=%0b dbg_gnt=%0b", k, dbg_req, dbg_gnt);
    end
    tick();
    cpu_req = 1'b0; dbg_req = 1'b0;
    #2;
    check("t6_dbg_valid", 32'(dbg_valid), 32'd1);
    check("t6_dbg_data", dbg_data, 32'hC0DE_0031);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
